// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W integer register file with per-register busy scoreboard.
// Optional same-cycle write-to-read bypass enabled by `define REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN     = 64,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            busy1,
  output logic            busy2,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);

  localparam int NREG = 1 << AW;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     cnt_nxt;

  logic wr_ok;
  logic iss_ok;
  logic rz1;
  logic rz2;

  assign wr_ok  = wen
    && !(ZERO_REG != 0 && waddr == '0);
  assign iss_ok = iss_en
    && !(ZERO_REG != 0 && iss_rd == '0);
  assign rz1 = ZERO_REG != 0 && raddr1 == '0;
  assign rz2 = ZERO_REG != 0 && raddr2 == '0;

  // Next busy vector: writeback clears, issue sets (newer owner wins),
  // flush squashes everything.
  always_comb begin
    busy_nxt = busy;
    if (wen)
      busy_nxt[waddr] = 1'b0;
    if (iss_ok)
      busy_nxt[iss_rd] = 1'b1;
    if (flush)
      busy_nxt = '0;
    if (ZERO_REG != 0)
      busy_nxt[0] = 1'b0;
  end

  // Population count of the next busy vector.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++)
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
  end

  // Data array write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Busy bits and their registered count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic hit1;
  logic hit2;

  assign hit1 = wr_ok && !rst
    && raddr1 == waddr;
  assign hit2 = wr_ok && !rst
    && raddr2 == waddr;

  // Read ports with writeback forwarding.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    busy1  = busy[raddr1];
    busy2  = busy[raddr2];
    if (hit1) begin
      rdata1 = wdata;
      if (!(iss_en && iss_rd == raddr1))
        busy1 = 1'b0;
    end
    if (hit2) begin
      rdata2 = wdata;
      if (!(iss_en && iss_rd == raddr2))
        busy2 = 1'b0;
    end
    if (rz1) begin
      rdata1 = '0;
      busy1  = 1'b0;
    end
    if (rz2) begin
      rdata2 = '0;
      busy2  = 1'b0;
    end
  end
`else
  // Read ports from stored state only.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    busy1  = busy[raddr1];
    busy2  = busy[raddr2];
    if (rz1) begin
      rdata1 = '0;
      busy1  = 1'b0;
    end
    if (rz2) begin
      rdata2 = '0;
      busy2  = 1'b0;
    end
  end
`endif

endmodule
